// File: rtl/cam_line_sched.sv
// Camera line capture into a ping-pong line buffer plus in-order UDP line-send scheduling.
// Define CAM_LINE_SCHED_STATS_EN to build the drop_cnt / frame_err statistics.
module cam_line_sched #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned V_ACTIVE = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_init_done,
    input  logic        vsync,
    input  logic        de,
    input  logic        pix_valid,
    output logic        buf_wr_en,
    output logic        buf_wr_bank,
    output logic [10:0] buf_wr_addr,
    output logic        tx_req,
    input  logic        tx_ack,
    input  logic        tx_done,
    output logic        tx_bank,
    output logic [9:0]  tx_line,
    output logic [7:0]  tx_frame,
    output logic [10:0] tx_len,
    output logic [15:0] drop_cnt,
    output logic        frame_err
);

    typedef enum logic [1:0] {StIdle, StWaitVs, StActive} state_e;
    typedef enum logic [1:0] {BankFree, BankWrite, BankFull} bank_e;

    localparam logic [11:0] HCnt = 12'(H_ACTIVE);
    localparam logic [10:0] VCnt = 11'(V_ACTIVE);

    state_e      state_q, state_d;
    bank_e       bank_q [2];
    bank_e       bank_d [2];
    logic [9:0]  line_of_q [2];
    logic [9:0]  line_of_d [2];
    logic        vsync_q, de_q;
    logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        wr_act_q, wr_act_d;
    logic        line_open_q, line_open_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic [7:0]  frame_q, frame_d;
    logic        req_q, req_d, inflight_q, inflight_d;
    logic        tx_bank_q, tx_bank_d;
    logic [9:0]  tx_line_q, tx_line_d;
    logic [10:0] tx_len_q, tx_len_d;
    logic        drop_evt, err_evt;

    logic        vs_rise, de_rise, de_fall, frame_start;
    logic        done_fire, ack_fire, claim, counting, writing;
    logic [11:0] pix_idx;

    assign vs_rise     = vsync & ~vsync_q;
    assign de_rise     = de & ~de_q;
    assign de_fall     = ~de & de_q;
    assign frame_start = vs_rise & cam_init_done & (state_q != StIdle);
    assign done_fire   = tx_done & inflight_q;
    assign ack_fire    = tx_ack & req_q;

    // A bank freed by tx_done this cycle is claimable by a line starting this cycle.
    assign claim = (state_q == StActive) & cam_init_done & de_rise & ~frame_start &
                   ((bank_q[wr_ptr_q] == BankFree) | (done_fire & (tx_bank_q == wr_ptr_q)));

    assign pix_idx  = claim ? 12'd0 : pix_cnt_q;
    assign counting = (claim | (wr_act_q & cam_init_done & ~frame_start)) & de & pix_valid &
                      (pix_idx <= HCnt);
    assign writing  = ~rst & counting & (pix_idx < HCnt);

    assign buf_wr_en   = writing;
    assign buf_wr_bank = writing & wr_ptr_q;
    assign buf_wr_addr = writing ? pix_idx[10:0] : 11'd0;
    assign tx_req      = req_q;
    assign tx_bank     = tx_bank_q;
    assign tx_line     = tx_line_q;
    assign tx_frame    = frame_q;
    assign tx_len      = tx_len_q;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        line_of_d   = line_of_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_act_d    = wr_act_q;
        line_open_d = line_open_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_d     = frame_q;
        req_d       = req_q;
        inflight_d  = inflight_q;
        tx_bank_d   = tx_bank_q;
        tx_line_d   = tx_line_q;
        tx_len_d    = tx_len_q;
        drop_evt    = 1'b0;
        err_evt     = 1'b0;

        if (done_fire) begin
            bank_d[tx_bank_q] = BankFree;
            inflight_d        = 1'b0;
            rd_ptr_d          = ~rd_ptr_q;
        end
        if (ack_fire) begin
            req_d      = 1'b0;
            inflight_d = 1'b1;
        end else if (!req_q && !inflight_q && bank_q[rd_ptr_q] == BankFull) begin
            req_d     = 1'b1;
            tx_bank_d = rd_ptr_q;
            tx_line_d = line_of_q[rd_ptr_q];
            tx_len_d  = 11'(H_ACTIVE);
        end

        // Only the write side aborts; queued and in-flight banks are left alone.
        if (!cam_init_done || frame_start) begin
            if (wr_act_q) bank_d[wr_ptr_q] = BankFree;
            wr_act_d    = 1'b0;
            line_open_d = 1'b0;
        end
        if (frame_start) begin
            frame_d    = frame_q + 8'd1;
            line_cnt_d = 11'd0;
        end

        if (!cam_init_done) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StWaitVs;
                StWaitVs: if (vs_rise) state_d = StActive;
                StActive: begin
                    if (!frame_start) begin
                        if (de_rise) begin
                            line_open_d = 1'b1;
                            pix_cnt_d   = 12'd0;
                            if (claim) begin
                                bank_d[wr_ptr_q]    = BankWrite;
                                line_of_d[wr_ptr_q] = line_cnt_q[9:0];
                                wr_act_d            = 1'b1;
                            end else begin
                                drop_evt = 1'b1;
                            end
                        end
                        if (counting) pix_cnt_d = pix_idx + 12'd1;
                        // A line cut short by frame start is not counted in the new frame.
                        if (de_fall && line_open_q) begin
                            line_open_d = 1'b0;
                            line_cnt_d  = line_cnt_q + 11'd1;
                            if (wr_act_q) begin
                                wr_act_d = 1'b0;
                                if (pix_cnt_q == HCnt) begin
                                    bank_d[wr_ptr_q] = BankFull;
                                    wr_ptr_d         = ~wr_ptr_q;
                                end else begin
                                    bank_d[wr_ptr_q] = BankFree;
                                    err_evt          = 1'b1;
                                end
                            end
                            if (11'(line_cnt_q + 11'd1) == VCnt) state_d = StWaitVs;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bank_q      <= '{BankFree, BankFree};
            line_of_q   <= '{10'd0, 10'd0};
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_act_q    <= 1'b0;
            line_open_q <= 1'b0;
            pix_cnt_q   <= 12'd0;
            line_cnt_q  <= 11'd0;
            frame_q     <= 8'd0;
            req_q       <= 1'b0;
            inflight_q  <= 1'b0;
            tx_bank_q   <= 1'b0;
            tx_line_q   <= 10'd0;
            tx_len_q    <= 11'd0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            line_of_q   <= line_of_d;
            vsync_q     <= vsync;
            de_q        <= de;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_act_q    <= wr_act_d;
            line_open_q <= line_open_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_q     <= frame_d;
            req_q       <= req_d;
            inflight_q  <= inflight_d;
            tx_bank_q   <= tx_bank_d;
            tx_line_q   <= tx_line_d;
            tx_len_q    <= tx_len_d;
        end
    end

`ifdef CAM_LINE_SCHED_STATS_EN
    logic [15:0] drop_q;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_evt;
            if (drop_evt && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt  = drop_q;
    assign frame_err = err_q;
`else
    logic stats_unused;
    assign stats_unused = drop_evt ^ err_evt;
    assign drop_cnt     = 16'd0;
    assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cam_line_sched.sv
// Self-checking bench for cam_line_sched: directed scenarios then randomized lines,
// checked against a line-level model of banks, queue, frame and line counters.
module tb_cam_line_sched;

    localparam int H = 1024;
    localparam int V = 6;
`ifdef CAM_LINE_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cam_init_done, vsync, de, pix_valid, tx_ack, tx_done;
    logic        buf_wr_en, buf_wr_bank, tx_req, tx_bank, frame_err;
    logic [10:0] buf_wr_addr, tx_len;
    logic [9:0]  tx_line;
    logic [7:0]  tx_frame;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    cam_line_sched #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst), .cam_init_done(cam_init_done), .vsync(vsync), .de(de),
        .pix_valid(pix_valid), .buf_wr_en(buf_wr_en), .buf_wr_bank(buf_wr_bank),
        .buf_wr_addr(buf_wr_addr), .tx_req(tx_req), .tx_ack(tx_ack), .tx_done(tx_done),
        .tx_bank(tx_bank), .tx_line(tx_line), .tx_frame(tx_frame), .tx_len(tx_len),
        .drop_cnt(drop_cnt), .frame_err(frame_err)
    );

    int errors = 0;
    int checks = 0;

    // Line-level model
    bit m_active, m_acked;
    bit m_busy [2];
    int m_wr, m_line, m_frame, m_drops;
    int q_bank[$];
    int q_line[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_active = 0; m_acked = 0; m_busy[0] = 0; m_busy[1] = 0;
        m_wr = 0; m_line = 0; m_frame = 0; m_drops = 0;
        q_bank.delete(); q_line.delete();
    endtask

    task automatic model_frame_start();
        m_frame = (m_frame + 1) % 256;
        m_line = 0;
        m_active = 1;
    endtask

    task automatic model_done();
        m_busy[q_bank[0]] = 0;
        void'(q_bank.pop_front());
        void'(q_line.pop_front());
        m_acked = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, buf_wr_en, 0);
        check({tag, "_wr_bank"}, buf_wr_bank, 0);
        check({tag, "_wr_addr"}, buf_wr_addr, 0);
        check({tag, "_tx_req"}, tx_req, 0);
        check({tag, "_tx_bank"}, tx_bank, 0);
        check({tag, "_tx_line"}, tx_line, 0);
        check({tag, "_tx_frame"}, tx_frame, 0);
        check({tag, "_tx_len"}, tx_len, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        next();
        vsync = 1'b0;
        next();
        model_frame_start();
    endtask

    task automatic req_stays_low(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, tx_req, 0);
            next();
        end
    endtask

    // Drives one de period of n pixels; abort_at >= 0 raises vsync when that many pixels
    // have been sent; done_rise pulses tx_done in the de rising cycle.
    task automatic send_line(input int n, input int abort_at, input bit done_rise);
        bit claim, aborted, err, en;
        int b, idx;
        if (done_rise) model_done();
        b = m_wr;
        claim = m_active && !m_busy[b];
        if (m_active && !claim) m_drops++;
        aborted = 0; err = 0; idx = 0;
        de = 1'b1;
        tx_done = done_rise;
        while (idx < n && !aborted) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            if (abort_at >= 0 && idx == abort_at) begin
                vsync = 1'b1;
                aborted = 1'b1;
                claim = 1'b0;
                model_frame_start();
            end
            en = claim && pix_valid && (idx < H);
            @(negedge clk);
            check("wr_en", buf_wr_en, en);
            if (en) begin
                check("wr_addr", buf_wr_addr, idx);
                check("wr_bank", buf_wr_bank, b);
            end
            if (pix_valid) idx++;
            next();
            tx_done = 1'b0;
            vsync = 1'b0;
        end
        de = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        check("wr_en_fall", buf_wr_en, 0);
        check("frame_err_fall", frame_err, 0);
        if (!aborted && m_active) begin
            if (claim) begin
                if (n == H) begin
                    m_busy[b] = 1;
                    q_bank.push_back(b);
                    q_line.push_back(m_line);
                    m_wr ^= 1;
                end else begin
                    err = 1;
                end
            end
            m_line++;
            if (m_line == V) m_active = 0;
        end
        next();
        @(negedge clk);
        check("frame_err_pulse", frame_err, STATS && err);
        check("drop_cnt", drop_cnt, STATS ? m_drops : 0);
        next();
        @(negedge clk);
        check("frame_err_clear", frame_err, 0);
        next();
    endtask

    task automatic serve(input int ack_delay, input bit do_done);
        int t;
        t = 0;
        @(negedge clk);
        while (tx_req !== 1'b1 && t < 20) begin
            next();
            @(negedge clk);
            t++;
        end
        check("tx_req_rise", tx_req, 1);
        check("tx_bank", tx_bank, q_bank[0]);
        check("tx_line", tx_line, q_line[0]);
        check("tx_frame", tx_frame, m_frame);
        check("tx_len", tx_len, H);
        for (int i = 0; i < ack_delay; i++) begin
            next();
            @(negedge clk);
            check("tx_req_hold", tx_req, 1);
            check("tx_line_hold", tx_line, q_line[0]);
            check("tx_bank_hold", tx_bank, q_bank[0]);
        end
        next();
        tx_ack = 1'b1;
        @(negedge clk);
        check("tx_req_at_ack", tx_req, 1);
        next();
        tx_ack = 1'b0;
        @(negedge clk);
        check("tx_req_after_ack", tx_req, 0);
        m_acked = 1;
        next();
        if (do_done) begin
            repeat ($urandom_range(0, 3)) next();
            tx_done = 1'b1;
            model_done();
            next();
            tx_done = 1'b0;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; cam_init_done = 1'b0; vsync = 1'b0; de = 1'b0; pix_valid = 1'b0;
        tx_ack = 1'b0; tx_done = 1'b0;
        model_reset();
        next();
        next();
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        next();

        // First line end to end; stray ack beforehand is ignored
        cam_init_done = 1'b1;
        next();
        vs_pulse();
        tx_ack = 1'b1;
        next();
        tx_ack = 1'b0;
        req_stays_low("stray_ack", 3);
        send_line(H, -1, 0);
        serve(5, 1);
        req_stays_low("req_once", 6);

        // Short line: error pulse, no request, bank reused by the next line
        send_line(1000, -1, 0);
        req_stays_low("short_no_req", 4);
        send_line(H, -1, 0);
        serve(2, 1);

        // vsync mid-line aborts the line and restarts the line count
        send_line(H, 500, 0);
        req_stays_low("abort_no_req", 4);
        @(negedge clk);
        check("frame_after_abort", tx_frame, m_frame);
        next();
        send_line(H, -1, 0);
        serve(1, 1);

        // Reset while a request is pending; late handshakes afterwards are ignored
        send_line(H, -1, 0);
        t = 0;
        @(negedge clk);
        while (tx_req !== 1'b1 && t < 20) begin
            next();
            @(negedge clk);
            t++;
        end
        check("req_before_rst", tx_req, 1);
        next();
        rst = 1'b1;
        next();
        @(negedge clk);
        check_all_zero("rst_mid");
        next();
        rst = 1'b0;
        model_reset();
        next();
        tx_ack = 1'b1;
        next();
        tx_ack = 1'b0;
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        req_stays_low("late_hs", 4);

        // Back-to-back lines with tx_done withheld; unacked tx_done is ignored
        vs_pulse();
        send_line(H, -1, 0);
        tx_done = 1'b1;
        next();
        tx_done = 1'b0;
        send_line(H, -1, 0);
        send_line(H, -1, 0);
        @(negedge clk);
        check("b2b_drops_model", drop_cnt, STATS ? 1 : 0);
        check("b2b_req_bank0", tx_bank, 0);
        next();

        // tx_done frees bank 0 in the same cycle the next line needs it
        serve(3, 0);
        send_line(H, -1, 1);
        serve(2, 1);
        serve(4, 1);

        // Randomized lines, vsyncs and service
        for (int r = 0; r < 8; r++) begin
            int sel, len;
            sel = $urandom_range(0, 9);
            len = (sel == 0) ? 1000 + $urandom_range(0, 20) :
                  (sel == 1) ? H + 1 + $urandom_range(0, 5) : H;
            if ($urandom_range(0, 3) == 0) vs_pulse();
            send_line(len, -1, 0);
            if (q_bank.size() > 0 && $urandom_range(0, 2) != 0) serve($urandom_range(0, 6), 1);
        end
        while (q_bank.size() > 0) serve($urandom_range(0, 6), 1);
        req_stays_low("drained", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_line_sched.md
CAM_LINE_SCHED -- requirements
Module: cam_line_sched

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 768, lines per frame.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cam_init_done  in  1  sensor I2C configuration complete.
REQ-006 SHALL have ports vsync, de, pix_valid  in  1 each  frame sync (active-high), line valid, one-cycle per-pixel strobe; all already in clk domain.
REQ-007 SHALL have ports buf_wr_en  out  1, buf_wr_bank  out  1, buf_wr_addr  out  11  ping-pong line-buffer write control.
REQ-008 SHALL have ports tx_req  out  1, tx_ack  in  1, tx_done  in  1  UDP line-send handshake.
REQ-009 SHALL have ports tx_bank  out  1, tx_line  out  10, tx_frame  out  8, tx_len  out  11  descriptor of the line to send.
REQ-010 SHALL have ports drop_cnt  out  16 and frame_err  out  1  statistics.

Function
REQ-011 SHALL implement FSM IDLE -> WAIT_VS (cam_init_done=1) -> ACTIVE (vsync rising edge) -> WAIT_VS (line count reaches V_ACTIVE); cam_init_done=0 forces IDLE from any state.
REQ-012 SHALL detect vsync/de edges against one-cycle registered copies; frame start = vsync rising edge.
REQ-013 SHALL, at each frame start in ACTIVE or WAIT_VS, increment tx_frame (mod 256), clear line counter, and abort any line being written.
REQ-014 SHALL, in ACTIVE on de rising edge, claim write bank wr_ptr if free, else mark the line dropped.
REQ-015 SHALL, for a claimed line, assert buf_wr_en in the same cycle as each pix_valid with de=1, buf_wr_addr = pixel index from 0, buf_wr_bank = wr_ptr; pixels beyond H_ACTIVE are not written.
REQ-016 SHALL, on de falling edge with pixel count == H_ACTIVE, mark bank full, toggle wr_ptr, and queue the line; other counts release the bank, do not queue, pulse frame_err one cycle.
REQ-017 SHALL increment the line counter on every de falling edge in ACTIVE, including dropped and errored lines.
REQ-018 SHALL, one cycle after a bank is queued and no request is outstanding, assert tx_req with tx_bank, tx_line, tx_len=H_ACTIVE held stable until tx_ack.
REQ-019 SHALL deassert tx_req the cycle after tx_ack=1, then hold the bank busy until tx_done=1, then free it and advance rd_ptr.
REQ-020 SHALL serve banks strictly in fill order (rd_ptr), at most one request outstanding.
REQ-021 SHALL ignore tx_ack without tx_req and tx_done without an acked request.
REQ-022 SHALL process tx_done freeing bank B and a de rising edge needing bank B in the same cycle by claiming B (no drop).
REQ-023 SHALL increment drop_cnt on each dropped line, saturating at 16'hFFFF.
REQ-024 SHALL leave queued/in-flight banks untouched by frame start or IDLE entry; only the write side aborts.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, both banks free, wr_ptr=rd_ptr=0, tx_frame=0, line counter 0, drop_cnt=0, and all outputs 0.
REQ-026 SHALL treat reset mid-transfer as abandoning the transfer; late tx_ack/tx_done after reset are ignored per REQ-021.

Configuration
REQ-027 SHALL, with CAM_LINE_SCHED_STATS_EN defined, implement drop_cnt and frame_err as above.
REQ-028 SHALL, without CAM_LINE_SCHED_STATS_EN, tie drop_cnt=0 and frame_err=0 with all other behaviour unchanged.

Verification
REQ-029 SHALL cover: init_done, vsync pulse, 1024-pixel line, tx_ack after 5 cycles, tx_done -> tx_req once, tx_line=0, tx_frame=1, tx_len=1024, bank 0 free.
REQ-030 SHALL cover: three back-to-back lines with tx_done withheld -> lines 0,1 queued in banks 0,1, line 2 dropped, drop_cnt=1.
REQ-031 SHALL cover: line of 1000 pixels -> frame_err one-cycle pulse, no tx_req, next 1024-pixel line uses same bank.
REQ-032 SHALL cover: vsync rising mid-line after 500 pixels -> line aborted, no tx_req, tx_frame incremented, line counter 0.
REQ-033 SHALL cover: tx_done for bank 0 coincident with de rising edge when both banks busy -> line written to bank 0, drop_cnt unchanged.
REQ-034 SHALL cover: rst asserted while tx_req high -> next cycle all outputs 0; without CAM_LINE_SCHED_STATS_EN, REQ-030 gives drop_cnt=0.
